sa_feeder: RTL and testbench
============================

# sa_feeder

Skew-generating input feeder for the N×N output-stationary systolic array of 8-bit pe cells. It buffers N data rows and N weight columns, each K bytes long. On start it clears the array, then drives the row-skewed din and column-skewed win streams into the array edge. It then drains the pipeline and pulses done when every PE accumulator holds its final dot product.

## Interface
Parameters:
- N, 4, array dimension (rows = columns); power of two ≥2
- KMAX, 16, maximum reduction length per run; power of two
- AW, $clog2(KMAX), buffer address width
- LW, $clog2(N), lane-select width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- wr_en  in  1  buffer write strobe
- wr_sel  in  1  0 = data buffer, 1 = weight buffer
- wr_lane  in  LW  row (data) or column (weight) index
- wr_addr  in  AW  element index k
- wr_data  in  8  unsigned byte
- k_len  in  AW+1  reduction length K, sampled with start
- start  in  1  run request, single-cycle pulse
- din_bus  out  8*N  row i drives bits [8i+7:8i] into pe din of row i, column 0
- win_bus  out  8*N  column j drives bits [8j+7:8j] into pe win of row 0, column j
- arr_clear  out  1  to clear input of every pe
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejected-start pulse

## Operation
- Storage: data[N][KMAX], weight[N][KMAX], 8-bit each. Not reset, so contents survive rst; tests must not depend on post-reset contents.
- Writes are accepted only in IDLE. A write with wr_en=1 while busy=1 is dropped silently.
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: a start with 1 ≤ k_len ≤ KMAX latches K and moves to CLEAR. A start with k_len=0 or k_len>KMAX pulses err, and the block stays in IDLE. start is ignored in every other state.
- CLEAR: 1 cycle; arr_clear=1; buses are 0. Next state is FEED with feed counter t=0.
- FEED: K+N-1 cycles, t = 0 … K+N-2.
  - Lane i of din_bus = data[i][t-i] if 0 ≤ t-i < K, else 0.
  - Lane j of win_bus = weight[j][t-j] if 0 ≤ t-j < K, else 0.
- DRAIN: N cycles with both buses 0. This lets the last operands propagate N-1 register hops and commit into the accumulator.
- DONE: 1 cycle; done=1; returns to IDLE.
- busy=1 in CLEAR, FEED, DRAIN and DONE; busy=0 in IDLE.
- A write and a start in the same IDLE cycle: the write commits, and its value is used by the run.
- Element k of row i meets element k of column j at PE(i,j) at feed time i+j+k. Every PE therefore accumulates sum over k of data[i][k]·weight[j][k], truncated mod 256 per the 8-bit PE adder.
- rst in any state forces IDLE on the next edge, drives every output to 0, and aborts the run with no done pulse.

## Timing
- All outputs are registered (Moore). Reset value of din_bus, win_bus, arr_clear, busy, done and err is 0.
- Cycle 0 is the edge that samples start. Relative to it:
  - arr_clear=1 and busy=1 in cycle 1.
  - Feed value t appears in cycle 2+t, for cycles 2 … K+N.
  - DRAIN occupies cycles K+N+1 … K+2N.
  - done=1 in cycle K+2N+1.
- err is asserted in cycle 1 after a rejected start.
- Back-to-back runs: a start in the cycle after done is accepted.
- Buffer reads are pipelined internally so that feed value t is valid exactly in cycle 2+t; no bubbles occur inside FEED.

## Test plan
- Reset: hold rst 2 cycles mid-idle → din_bus=0, win_bus=0, arr_clear=0, busy=0, done=0, err=0.
- Skew pattern (N=4, K=4): set data[i][k]=4i+k+1 and weight[j][k]=0x10·j+k, then start →
  - arr_clear in cycle 1.
  - din lane0 = 1,2,3,4 in cycles 2–5; din lane3 = 13,14,15,16 in cycles 5–8; 0 otherwise.
  - win lane2 = 0x20..0x23 in cycles 4–7.
  - done in cycle 13.
- Length bounds:
  - k_len=1 → done in cycle 10.
  - k_len=16 → done in cycle 25.
  - k_len=0 or 17 → err in cycle 1, busy stays 0.
- Busy protection: during FEED, write data[0][0]=0xFF and pulse start → current streams are unchanged, there is no second run, and the next run still feeds the old data[0][0].
- Abort: assert rst in cycle 6 of a K=4 run → all outputs 0 from cycle 7, no done; a fresh start then completes normally.
- System: feeder driving a 4×4 pe array, data all 2, weights all 3, K=4 → every PE out = 24 at done; with data=weights=0x10 and K=2, every PE out = 0x00 (mod-256 wrap).

Source files
------------

// File: rtl/sa_feeder.sv
// Skew-generating operand feeder for an N x N output-stationary systolic array.
// Buffers N data rows and N weight columns, then streams them diagonally skewed into the array edge.

module sa_feeder_lane #(
    parameter int KMAX = 16,
    parameter int AW   = 4,
    parameter int CW   = 6,
    parameter int LANE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_we,
    input  logic          w_we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          feed_en,
    input  logic [CW-1:0] feed_t,
    input  logic [AW:0]   k_len,
    output logic [7:0]    din_q,
    output logic [7:0]    win_q
);
    localparam logic [CW-1:0] LANE_C = CW'(LANE);

    logic [7:0]    dmem_q [KMAX];
    logic [7:0]    wmem_q [KMAX];
    logic [CW-1:0] idx;
    logic          hit;
    logic [7:0]    din_d;
    logic [7:0]    win_d;

    // Operand storage deliberately has no reset so buffered operands survive rst.
    always_ff @(posedge clk) begin
        if (d_we) dmem_q[wr_addr] <= wr_data;
        if (w_we) wmem_q[wr_addr] <= wr_data;
    end

    // Lane i lags the feed counter by i cycles; outside [0, K) the lane idles at zero.
    always_comb begin
        idx   = feed_t - LANE_C;
        hit   = feed_en && (feed_t >= LANE_C) && (idx < CW'(k_len));
        din_d = '0;
        win_d = '0;
        if (hit) begin
            din_d = dmem_q[idx[AW-1:0]];
            win_d = wmem_q[idx[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= '0;
            win_q <= '0;
        end else begin
            din_q <= din_d;
            win_q <= win_d;
        end
    end
endmodule

module sa_feeder #(
    parameter int N    = 4,
    parameter int KMAX = 16,
    parameter int AW   = $clog2(KMAX),
    parameter int LW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic           wr_sel,
    input  logic [LW-1:0]  wr_lane,
    input  logic [AW-1:0]  wr_addr,
    input  logic [7:0]     wr_data,
    input  logic [AW:0]    k_len,
    input  logic           start,
    output logic [8*N-1:0] din_bus,
    output logic [8*N-1:0] win_bus,
    output logic           arr_clear,
    output logic           busy,
    output logic           done,
    output logic           err
);
    localparam int CW = $clog2(KMAX + N) + 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW:0]   k_q, k_d;
    logic          k_ok;
    logic          wr_ok;

    logic          arr_clear_q, arr_clear_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          feed_en;

    logic [N-1:0][7:0] din_lane;
    logic [N-1:0][7:0] win_lane;

    assign k_ok  = (k_len != '0) && (k_len <= (AW+1)'(KMAX));
    assign wr_ok = wr_en && (state_q == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start && k_ok) begin
                    k_d     = k_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                // K+N-1 feed slots: the last lane's final element leaves at t = K+N-2.
                if (cnt_q == CW'(k_q) + CW'(N - 2)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(N - 1)) state_d = S_DONE;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a plain register.
    always_comb begin
        arr_clear_d = (state_d == S_CLEAR);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        err_d       = (state_q == S_IDLE) && start && !k_ok;
        feed_en     = (state_d == S_FEED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arr_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            arr_clear_q <= arr_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        sa_feeder_lane #(
            .KMAX (KMAX),
            .AW   (AW),
            .CW   (CW),
            .LANE (g)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .d_we    (wr_ok && !wr_sel && (wr_lane == LW'(g))),
            .w_we    (wr_ok &&  wr_sel && (wr_lane == LW'(g))),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .feed_en (feed_en),
            .feed_t  (cnt_d),
            .k_len   (k_q),
            .din_q   (din_lane[g]),
            .win_q   (win_lane[g])
        );
    end

    assign din_bus   = din_lane;
    assign win_bus   = win_lane;
    assign arr_clear = arr_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_sa_feeder.sv
// Scoreboard bench for sa_feeder: per-cycle expected outputs and final PE dot products are queued
// at start time from a spec-level model; a negedge monitor pops and compares.
module tb_sa_feeder;
    localparam int N    = 4;
    localparam int KMAX = 16;
    localparam int AW   = 4;
    localparam int LW   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_en = 1'b0;
    logic           wr_sel = 1'b0;
    logic [LW-1:0]  wr_lane = '0;
    logic [AW-1:0]  wr_addr = '0;
    logic [7:0]     wr_data = '0;
    logic [AW:0]    k_len = '0;
    logic           start = 1'b0;
    logic [8*N-1:0] din_bus, win_bus;
    logic           arr_clear, busy, done, err;

    sa_feeder #(.N(N), .KMAX(KMAX)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_lane(wr_lane),
        .wr_addr(wr_addr), .wr_data(wr_data), .k_len(k_len), .start(start),
        .din_bus(din_bus), .win_bus(win_bus), .arr_clear(arr_clear),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural N x N output-stationary PE array fed by the DUT buses.
    logic [7:0] pa [N][N];
    logic [7:0] pb [N][N];
    logic [7:0] acc[N][N];

    function automatic logic [7:0] a_in(int i, int j);
        if (j == 0) return din_bus[8*i +: 8];
        return pa[i][j-1];
    endfunction

    function automatic logic [7:0] b_in(int i, int j);
        if (i == 0) return win_bus[8*j +: 8];
        return pb[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (arr_clear) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end else begin
                    pa[i][j]  <= a_in(i, j);
                    pb[i][j]  <= b_in(i, j);
                    acc[i][j] <= acc[i][j] + a_in(i, j) * b_in(i, j);
                end
            end
        end
    end

    // Reference buffer contents.
    logic [7:0] dm[N][KMAX];
    logic [7:0] wm[N][KMAX];

    typedef struct {
        int             cyc;
        int             run;
        int             n;
        logic [8*N-1:0] din;
        logic [8*N-1:0] win;
        logic [3:0]     ctl;   // {arr_clear, busy, done, err}
    } exp_t;

    typedef struct {
        int               run;
        logic [8*N*N-1:0] v;
    } dot_t;

    exp_t exp_q[$];
    dot_t dot_q[$];
    int   checks = 0;
    int   passes = 0;
    int   run_id = 0;

    function automatic exp_t idle_rec(int c, int n);
        exp_t r;
        r.cyc = c; r.run = run_id; r.n = n;
        r.din = '0; r.win = '0; r.ctl = 4'b0000;
        return r;
    endfunction

    // Cycle n of a run (n=1 is the cycle after the start edge).
    function automatic exp_t run_rec(int e0, int k, int n);
        exp_t r;
        r = idle_rec(e0 + n - 1, n);
        r.ctl = {n == 1, 1'b1, n == k + 2*N + 1, 1'b0};
        if (n >= 2 && n <= k + N) begin
            for (int i = 0; i < N; i++) begin
                int x;
                x = (n - 2) - i;
                if (x >= 0 && x < k) begin
                    r.din[8*i +: 8] = dm[i][x];
                    r.win[8*i +: 8] = wm[i][x];
                end
            end
        end
        return r;
    endfunction

    function automatic dot_t dot_rec(int k);
        dot_t d;
        d.run = run_id;
        d.v = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int x = 0; x < k; x++) s += int'(dm[i][x]) * int'(wm[j][x]);
                d.v[8*(i*N+j) +: 8] = 8'(s % 256);
            end
        end
        return d;
    endfunction

    exp_t             m_e;
    dot_t             m_d;
    logic [8*N*N-1:0] m_acc;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            m_e = exp_q.pop_front();
            checks++;
            $display("FAIL missed_sample run=%0d n=%0d at cycle %0d", m_e.run, m_e.n, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            m_e = exp_q.pop_front();
            checks++;
            if (din_bus === m_e.din && win_bus === m_e.win &&
                {arr_clear, busy, done, err} === m_e.ctl)
                passes++;
            else
                $display("FAIL outputs run=%0d n=%0d: got din=%h win=%h clr/busy/done/err=%b, want din=%h win=%h %b",
                         m_e.run, m_e.n, din_bus, win_bus, {arr_clear, busy, done, err},
                         m_e.din, m_e.win, m_e.ctl);
        end
        if (done === 1'b1) begin
            checks++;
            if (dot_q.size() == 0) begin
                $display("FAIL spurious_done at cycle %0d: got done=1, want 0", cyc);
            end else begin
                m_d = dot_q.pop_front();
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) m_acc[8*(i*N+j) +: 8] = acc[i][j];
                if (m_acc === m_d.v) passes++;
                else $display("FAIL pe_acc run=%0d: got %h, want %h", m_d.run, m_acc, m_d.v);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr_byte(input bit sel, input int lane, input int addr, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_lane = LW'(lane); wr_addr = AW'(addr); wr_data = data;
        if (sel) wm[lane][addr] = data;
        else     dm[lane][addr] = data;
        step();
        wr_en = 1'b0;
    endtask

    // mode: 0 plain, 1 write in the start cycle, 2 write+start during FEED, 3 rst in cycle 6
    task automatic start_run(input int k, input int mode);
        int e0;
        int last;
        bit ok;
        ok = (k >= 1 && k <= KMAX);
        run_id++;
        if (mode == 1) begin
            int l, a;
            bit s;
            logic [7:0] v;
            s = 1'($urandom % 2); l = $urandom_range(0, N-1); a = $urandom_range(0, k-1);
            v = 8'($urandom);
            wr_en = 1'b1; wr_sel = s; wr_lane = LW'(l); wr_addr = AW'(a); wr_data = v;
            if (s) wm[l][a] = v;
            else   dm[l][a] = v;
        end
        start = 1'b1;
        k_len = (AW+1)'(k);
        e0 = cyc + 1;
        if (!ok) begin
            exp_t r;
            r = idle_rec(e0, 1);
            r.ctl = 4'b0001;
            exp_q.push_back(r);
            exp_q.push_back(idle_rec(e0 + 1, 2));
            step();
            start = 1'b0; wr_en = 1'b0;
            step();
            return;
        end
        last = (mode == 3) ? 6 : k + 2*N + 1;
        for (int n = 1; n <= last; n++) exp_q.push_back(run_rec(e0, k, n));
        if (mode == 3) begin
            for (int n = 7; n <= k + 2*N + 2; n++) exp_q.push_back(idle_rec(e0 + n - 1, n));
        end else begin
            exp_q.push_back(idle_rec(e0 + k + 2*N + 1, k + 2*N + 2));
            dot_q.push_back(dot_rec(k));
        end
        step();
        start = 1'b0; wr_en = 1'b0;
        for (int s = 1; s <= k + 2*N; s++) begin
            wr_en = 1'b0; start = 1'b0;
            rst = (mode == 3 && s == 6);
            if (mode == 2 && s == 4) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_lane = '0; wr_addr = '0; wr_data = 8'hFF;
                start = 1'b1; k_len = (AW+1)'(4);
            end
            step();
        end
        wr_en = 1'b0; start = 1'b0; rst = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        exp_q.push_back(idle_rec(cyc + 1, 0));
        exp_q.push_back(idle_rec(cyc + 2, 0));
        step();
        rst = 1'b0;
        repeat (2) step();

        for (int s = 0; s < 2; s++)
            for (int l = 0; l < N; l++)
                for (int a = 0; a < KMAX; a++) wr_byte(1'(s), l, a, 8'($urandom));

        // Skew pattern
        for (int i = 0; i < N; i++)
            for (int x = 0; x < 4; x++) begin
                wr_byte(1'b0, i, x, 8'(4*i + x + 1));
                wr_byte(1'b1, i, x, 8'(16*i + x));
            end
        start_run(4, 0);

        // Length bounds, then back-to-back
        start_run(1, 0);
        start_run(16, 0);
        start_run(0, 0);
        start_run(17, 0);

        // Mid-idle reset
        step();
        rst = 1'b1;
        for (int c = 1; c <= 4; c++) exp_q.push_back(idle_rec(cyc + c, 0));
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        // Busy protection then a run that must still see the old data[0][0]
        start_run(4, 2);
        start_run(4, 0);

        // Abort then a fresh run
        start_run(4, 3);
        start_run(4, 0);

        // System patterns: 4*(2*3)=24 and 2*(16*16)=512 -> 0 mod 256
        for (int l = 0; l < N; l++)
            for (int a = 0; a < 4; a++) begin
                wr_byte(1'b0, l, a, 8'd2);
                wr_byte(1'b1, l, a, 8'd3);
            end
        start_run(4, 0);
        for (int l = 0; l < N; l++)
            for (int a = 0; a < 2; a++) begin
                wr_byte(1'b0, l, a, 8'h10);
                wr_byte(1'b1, l, a, 8'h10);
            end
        start_run(2, 0);

        // Random runs
        for (int r = 0; r < 20; r++) begin
            int nw;
            nw = $urandom_range(0, 6);
            for (int w = 0; w < nw; w++)
                wr_byte(1'($urandom % 2), $urandom_range(0, N-1), $urandom_range(0, KMAX-1), 8'($urandom));
            if ($urandom_range(0, 5) == 0)
                start_run(($urandom % 2) ? 0 : $urandom_range(17, 31), 0);
            else
                start_run($urandom_range(1, KMAX), ($urandom_range(0, 2) == 0) ? 1 : 0);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        checks++;
        if (exp_q.size() == 0 && dot_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d output and %0d done entries pending, want 0 and 0",
                      exp_q.size(), dot_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
